// File: rtl/npp_pkg.sv
// Shared definitions for the NoC packet port receive buffer: framing FSM
// state encoding and the bit layout of incoming flits and stored entries.
package npp_pkg;

    typedef enum logic [0:0] {
        NPP_IDLE   = 1'b0,
        NPP_IN_PKT = 1'b1
    } npp_state_e;

    // The valid bit sits directly above the payload in noc_data
    function automatic int npp_valid_idx(input int data_width);
        return data_width;
    endfunction

    // Stored entry layout is {tail, head, payload}
    function automatic int npp_head_pos(input int data_width);
        return data_width;
    endfunction

    function automatic int npp_tail_pos(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int npp_entry_width(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/npp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rdata whenever the FIFO is not empty; rdata reads as zero when empty.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module npp_sync_fifo #(
    parameter int WIDTH = 130,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/npp_rx_buffer.sv
// Receive-side NoC packet port buffer. Checks head/tail framing on the
// router ejection stream, buffers accepted flits with their flags, and
// hands them to the consumer over valid/ready, returning one credit per
// popped flit.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   NPP_IDLE   | between packets; only a head flit is accepted
//   NPP_IN_PKT | head seen, waiting for body/tail flits of that packet
//
// A head arriving mid-packet is flagged but still stored: it abandons the
// old packet and starts a new one. Overflow drops the flit but the FSM
// advances as though it had been stored, so framing stays in step with
// the router.
module npp_rx_buffer
    import npp_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH:0]   noc_data,
    input  logic                  s_is_head,
    input  logic                  s_is_tail,
    output logic                  npp_valid,
    input  logic                  npp_ready,
    output logic [DATA_WIDTH-1:0] npp_data,
    output logic                  npp_head,
    output logic                  npp_tail,
    output logic                  credit_return,
    output logic                  err_framing,
    output logic                  err_overflow,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  in_packet
);

    localparam int VLD_IDX  = npp_valid_idx(DATA_WIDTH);
    localparam int HEAD_POS = npp_head_pos(DATA_WIDTH);
    localparam int TAIL_POS = npp_tail_pos(DATA_WIDTH);
    localparam int EW       = npp_entry_width(DATA_WIDTH);
    localparam int AW       = $clog2(DEPTH);

    npp_state_e            r_state;
    logic                  r_in_packet;
    logic                  r_err_framing;
    logic                  r_err_overflow;
    logic                  r_credit;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    npp_state_e            w_next_state;
    logic                  w_in_vld;
    logic                  w_head;
    logic                  w_tail;
    logic                  w_accept;
    logic                  w_frame_err;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_push;
    logic                  w_overflow;
    logic [EW-1:0]         w_wdata;
    logic [EW-1:0]         w_rdata;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [AW:0]           w_fifo_count;

    assign w_in_vld = noc_data[VLD_IDX];
    assign w_head   = w_in_vld & s_is_head;
    assign w_tail   = w_in_vld & s_is_tail;
    assign w_wdata  = {w_tail, w_head, noc_data[DATA_WIDTH-1:0]};

    assign w_pop      = npp_valid & npp_ready;
    assign w_room     = (w_fifo_count < (AW+1)'(DEPTH));
    assign w_push     = w_accept & (w_room | w_pop);
    assign w_overflow = w_accept & w_fifo_full & ~w_pop;

    // Framing decode: which flits are accepted, which are errors, where next
    always_comb begin
        w_accept     = 1'b0;
        w_frame_err  = 1'b0;
        w_next_state = r_state;
        if (w_in_vld) begin
            case (r_state)
                NPP_IDLE: begin
                    if (w_head) begin
                        w_accept     = 1'b1;
                        w_next_state = w_tail ? NPP_IDLE : NPP_IN_PKT;
                    end else begin
                        w_frame_err  = 1'b1;
                    end
                end
                NPP_IN_PKT: begin
                    w_accept     = 1'b1;
                    w_frame_err  = w_head;
                    w_next_state = w_tail ? NPP_IDLE : NPP_IN_PKT;
                end
                default: begin
                    w_next_state = NPP_IDLE;
                end
            endcase
        end
    end

    // Framing FSM with its registered status outputs and packet counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= NPP_IDLE;
            r_in_packet    <= 1'b0;
            r_err_framing  <= 1'b0;
            r_err_overflow <= 1'b0;
            r_pkt_count    <= '0;
        end else begin
            r_state        <= w_next_state;
            r_in_packet    <= (w_next_state == NPP_IN_PKT);
            r_err_framing  <= w_frame_err;
            r_err_overflow <= w_overflow;
            if (w_push && w_tail) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    // One credit back to the router for every flit the consumer takes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
        end
    end

    npp_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign npp_valid     = ~w_fifo_empty;
    assign npp_data      = w_rdata[DATA_WIDTH-1:0];
    assign npp_head      = w_rdata[HEAD_POS];
    assign npp_tail      = w_rdata[TAIL_POS];
    assign credit_return = r_credit;
    assign err_framing   = r_err_framing;
    assign err_overflow  = r_err_overflow;
    assign pkt_count     = r_pkt_count;
    assign in_packet     = r_in_packet;

endmodule

// File: tb/tb_npp_rx_buffer.sv
// Bench for npp_rx_buffer: directed packet scenarios followed by random
// traffic, compared each cycle against a queue-based packet model.
module tb_npp_rx_buffer;

    localparam int DW    = 128;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk;
    logic          rst;
    logic [DW:0]   noc_data;
    logic          s_is_head;
    logic          s_is_tail;
    logic          npp_valid;
    logic          npp_ready;
    logic [DW-1:0] npp_data;
    logic          npp_head;
    logic          npp_tail;
    logic          credit_return;
    logic          err_framing;
    logic          err_overflow;
    logic [CW-1:0] pkt_count;
    logic          in_packet;

    npp_rx_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noc_data      (noc_data),
        .s_is_head     (s_is_head),
        .s_is_tail     (s_is_tail),
        .npp_valid     (npp_valid),
        .npp_ready     (npp_ready),
        .npp_data      (npp_data),
        .npp_head      (npp_head),
        .npp_tail      (npp_tail),
        .credit_return (credit_return),
        .err_framing   (err_framing),
        .err_overflow  (err_overflow),
        .pkt_count     (pkt_count),
        .in_packet     (in_packet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: buffered entries are {tail, head, payload}
    logic [DW+1:0] m_q[$];
    bit            m_in_pkt;
    int            m_cnt;
    bit            m_credit;
    bit            m_frm;
    bit            m_ovf;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_pkt = 0;
        m_cnt    = 0;
        m_credit = 0;
        m_frm    = 0;
        m_ovf    = 0;
    endtask

    task automatic check_outputs();
        logic [DW+1:0] front;
        front = (m_q.size() != 0) ? m_q[0] : '0;
        chk("valid", npp_valid, (m_q.size() != 0));
        chk("data", npp_data, front[DW-1:0]);
        chk("head", npp_head, front[DW]);
        chk("tail", npp_tail, front[DW+1]);
        chk("credit", credit_return, m_credit);
        chk("err_framing", err_framing, m_frm);
        chk("err_overflow", err_overflow, m_ovf);
        chk("pkt_count", pkt_count, DW'(m_cnt % (1 << CW)));
        chk("in_packet", in_packet, m_in_pkt);
    endtask

    // drive one cycle of input, advance the model, then check after the edge
    task automatic step(input bit vld, input bit h, input bit t, input logic [DW-1:0] pl, input bit rdy);
        bit hv, tv, accept, pop, wr;
        noc_data  = {vld, pl};
        s_is_head = h;
        s_is_tail = t;
        npp_ready = rdy;

        hv     = vld && h;
        tv     = vld && t;
        pop    = rdy && (m_q.size() != 0);
        accept = vld && (m_in_pkt || hv);
        m_frm  = vld && (m_in_pkt ? hv : !hv);
        wr     = accept && ((m_q.size() < DEPTH) || pop);
        m_ovf  = accept && !wr;
        if (accept) m_in_pkt = !tv;
        if (pop) void'(m_q.pop_front());
        if (wr) begin
            m_q.push_back({tv, hv, pl});
            if (tv) m_cnt++;
        end
        m_credit = pop;

        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [DW-1:0] rnd_payload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst       = 1'b1;
        noc_data  = '0;
        s_is_head = 1'b0;
        s_is_tail = 1'b0;
        npp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // single-flit packet, consumer ready
        step(1, 1, 1, DW'(16'h1234), 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);

        // four-flit packet held back, then drained
        step(1, 1, 0, rnd_payload(), 0);
        step(1, 0, 0, rnd_payload(), 0);
        step(1, 0, 0, rnd_payload(), 0);
        step(1, 0, 1, rnd_payload(), 0);
        repeat (6) step(0, 0, 0, '0, 1);

        // body while idle, tail while idle, invalid flags ignored
        step(1, 0, 0, rnd_payload(), 0);
        step(1, 0, 1, rnd_payload(), 0);
        step(0, 1, 1, rnd_payload(), 0);

        // head inside a packet, then close it
        step(1, 1, 0, rnd_payload(), 0);
        step(1, 1, 0, rnd_payload(), 0);
        step(1, 1, 1, rnd_payload(), 0);
        repeat (4) step(0, 0, 0, '0, 1);

        // overflow: nine flits into eight slots, then push with pop at full
        step(1, 1, 0, rnd_payload(), 0);
        repeat (8) step(1, 0, 0, rnd_payload(), 0);
        step(1, 0, 0, rnd_payload(), 1);
        step(1, 0, 1, rnd_payload(), 1);
        repeat (10) step(0, 0, 0, '0, 1);

        // reset mid-packet with flits buffered
        step(1, 1, 1, rnd_payload(), 0);
        step(1, 1, 0, rnd_payload(), 0);
        step(1, 0, 0, rnd_payload(), 0);
        step(1, 0, 0, rnd_payload(), 0);
        rst       = 1'b1;
        noc_data  = '0;
        npp_ready = 1'b1;
        #1;
        chk("rst_valid", npp_valid, 1'b0);
        chk("rst_pkt_count", pkt_count, '0);
        chk("rst_in_packet", in_packet, 1'b0);
        chk("rst_credit", credit_return, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(0, 0, 0, '0, 1);
        step(1, 0, 1, rnd_payload(), 1);
        step(1, 1, 1, rnd_payload(), 1);
        step(0, 0, 0, '0, 1);

        // random traffic with phases of mostly-ready, balanced, mostly-stalled
        for (int i = 0; i < 3000; i++) begin
            int  rpct;
            bit  vld, h, t, rdy;
            case ((i / 150) % 3)
                0:       rpct = 90;
                1:       rpct = 50;
                default: rpct = 10;
            endcase
            vld = ($urandom_range(0, 3) != 0);
            h   = ($urandom_range(0, 3) == 0);
            t   = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 99) < rpct);
            step(vld, h, t, rnd_payload(), rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/npp_rx_buffer.md
# npp_rx_buffer

Receive-side NoC packet port (NPP) buffer between the NoC router's ejection flit stream and the NPP consumer logic. Extracts the flit valid bit (MSB of `noc_data`), checks head/tail framing, stores accepted flits with their head/tail flags in a first-word-fall-through FIFO, and presents them on a valid/ready interface. Each popped flit returns one credit to the router. Framing and overflow errors are reported as single-cycle pulses, and completed packets are counted.

## Interface
- `DATA_WIDTH`, 128, flit payload width; `noc_data` is `DATA_WIDTH+1` bits wide.
- `DEPTH`, 8, FIFO depth in flits; power of two, minimum 2.
- `CNT_WIDTH`, 16, width of the packet counter.
- `clk  in  1` — single clock.
- `rst  in  1` — asynchronous, active-high reset.
- `noc_data  in  DATA_WIDTH+1` — `[DATA_WIDTH]` = flit valid, `[DATA_WIDTH-1:0]` = payload.
- `s_is_head  in  1` — flit is packet head; qualified by the valid bit.
- `s_is_tail  in  1` — flit is packet tail; qualified by the valid bit.
- `npp_valid  out  1` — output flit available.
- `npp_ready  in  1` — consumer accepts the flit.
- `npp_data  out  DATA_WIDTH` — output payload.
- `npp_head  out  1` — output flit is a head.
- `npp_tail  out  1` — output flit is a tail.
- `credit_return  out  1` — one-cycle pulse per popped flit.
- `err_framing  out  1` — one-cycle pulse on a framing violation.
- `err_overflow  out  1` — one-cycle pulse when a flit is dropped because the FIFO is full.
- `pkt_count  out  CNT_WIDTH` — number of tails accepted into the FIFO; wraps.
- `in_packet  out  1` — framing FSM state is IN_PKT.

## Operation
- Incoming flit is present when `in_vld = noc_data[DATA_WIDTH]`. Head and tail flags are ignored unless `in_vld` is high.
- Framing FSM has two states: IDLE (reset state) and IN_PKT.
  - IDLE, head, no tail: write flit; go to IN_PKT.
  - IDLE, head and tail: single-flit packet. Write flit, stay in IDLE, increment `pkt_count`.
  - IDLE, no head: drop flit, pulse `err_framing`, stay in IDLE.
  - IN_PKT, no head, no tail: write flit (body).
  - IN_PKT, tail, no head: write flit, increment `pkt_count`, go to IDLE.
  - IN_PKT, head: pulse `err_framing`. Write the flit as a new packet start. Next state is IDLE if the tail is also set (and `pkt_count` increments); otherwise stay in IN_PKT.
- Push condition: flit is written when the FSM accepts it and (`count < DEPTH` or a pop occurs in the same cycle).
- Overflow: an accepted flit that finds the FIFO full with no pop is dropped. `err_overflow` pulses.
  - The FSM still advances as if the flit were written.
  - `pkt_count` does not increment for a dropped tail.
- Pop: `npp_valid & npp_ready`. `credit_return` equals the pop, registered (pulse in the cycle after the pop).
- FIFO storage per entry: {tail, head, payload}, i.e. `DATA_WIDTH+2` bits. Pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is `$clog2(DEPTH)+1` bits.
- `pkt_count` wraps from all-ones to 0.

## Timing
- Reset values: `npp_valid` 0, `credit_return` 0, `err_framing` 0, `err_overflow` 0, `pkt_count` 0, `in_packet` 0. FIFO pointers and occupancy are 0; FSM is in IDLE. `npp_data`, `npp_head` and `npp_tail` are 0 while empty.
- Latency:
  - A flit sampled on edge N is visible with `npp_valid` high after edge N (one cycle, input to output).
  - Pop on edge N produces `credit_return` high during cycle N+1.
- `npp_data`, `npp_head` and `npp_tail` hold stable while `npp_valid` is high and `npp_ready` is low.
- Simultaneous push and pop: occupancy is unchanged. This applies when full (push accepted) and when empty (not possible; valid is low).
- `err_framing` and `err_overflow` can pulse in the same cycle.
- Reset mid-packet: FIFO contents are discarded and the FSM returns to IDLE. The first flit after reset must be a head.

## Structure
- Package `npp_pkg`:
  - FSM state encoding (`NPP_IDLE`, `NPP_IN_PKT`).
  - Flit field offsets: valid bit index, head/tail bit positions inside the stored entry.
- Sub-module `npp_sync_fifo`:
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: push, pop, `wdata`, `rdata`, `full`, `empty`, `count`.
  - First-word-fall-through; push is allowed when full if a pop occurs in the same cycle.
- The top level holds the FSM, counters, error pulses and the credit register.

## Test plan
- Single-flit packet: head+tail, payload 0x1234, `npp_ready`=1. Expect `npp_valid` next cycle with head=tail=1, `pkt_count`=1, `credit_return` one cycle after the pop.
- Four-flit packet H,B,B,T with `npp_ready`=0, then ready=1. Expect 4 flits out in order, flags 10/00/00/01, 4 credit pulses, `in_packet` high between H and T.
- Body flit while IDLE. Expect `err_framing` pulse, nothing written, occupancy 0.
- Head while IN_PKT. Expect `err_framing` pulse, flit stored with head=1, `in_packet` stays 1.
- With `DEPTH`=8 and `npp_ready`=0, push 9 flits. Expect 9th dropped, `err_overflow` pulse, occupancy 8. Repeat with a pop in the same cycle as the 9th push: no error, occupancy stays 8.
- Assert `rst` mid-packet with 3 flits buffered. Expect `npp_valid`=0, `pkt_count`=0, `in_packet`=0 immediately, and no credit pulses.
